// File: rtl/mem_arbiter_if.sv
// SRAM-style two-phase bus shared by fetch and data access.
// Address phase: req/addr_ok; data phase: data_ok/rdata.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req;
   logic [3:0]            wen;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  addr_ok;
   logic                  data_ok;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output req, wen, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wen, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data bus arbiter: one outstanding transaction,
// alternating grant on ties, stall until every access completes.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inst_req,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   output logic [DATA_WIDTH-1:0] inst_rdata,
   output logic                  inst_ready,
   input  logic                  data_req,
   input  logic [3:0]            data_wen,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0] data_wdata,
   output logic [DATA_WIDTH-1:0] data_rdata,
   output logic                  data_ready,
   mem_arbiter_if.master         bus,
   output logic                  stall_req
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      DONE
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic                  grant_q;
   logic                  last_grant_q;
   logic                  pick_data;
   logic                  any_req;
   logic [3:0]            wen_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   // data wins alone, or on a tie when inst went last
   assign any_req   = inst_req | data_req;
   assign pick_data = data_req & (~inst_req | ~last_grant_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (any_req) state_d = ADDR;
         ADDR: if (bus.addr_ok) state_d = DATA;
         DATA: if (bus.data_ok) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_q      <= 1'b0;
         last_grant_q <= 1'b0;
         wen_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         if (state_q == IDLE && any_req) begin
            grant_q      <= pick_data;
            last_grant_q <= pick_data;
            wen_q        <= pick_data ? data_wen : 4'b0000;
            addr_q       <= pick_data ? data_addr : inst_addr;
            wdata_q      <= pick_data ? data_wdata : '0;
         end
         if (state_q == DATA && bus.data_ok) begin
            rdata_q <= bus.rdata;
         end
      end
   end

   assign bus.req   = (state_q == ADDR);
   assign bus.wen   = bus.req ? wen_q : 4'b0000;
   assign bus.addr  = bus.req ? addr_q : '0;
   assign bus.wdata = bus.req ? wdata_q : '0;

   assign inst_ready = (state_q == DONE) & ~grant_q;
   assign data_ready = (state_q == DONE) & grant_q;
   assign inst_rdata = rdata_q;
   assign data_rdata = rdata_q;

   assign stall_req = (inst_req & ~inst_ready)
                    | (data_req & ~data_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard of
// expected grants; the bench acts as requesters and bus slave.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      bit          is_data;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          inst_req = 1'b0;
   logic [AW-1:0] inst_addr = '0;
   logic [DW-1:0] inst_rdata;
   logic          inst_ready;
   logic          data_req = 1'b0;
   logic [3:0]    data_wen = '0;
   logic [AW-1:0] data_addr = '0;
   logic [DW-1:0] data_wdata = '0;
   logic [DW-1:0] data_rdata;
   logic          data_ready;
   logic          stall_req;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   n_iready = 0;
   int   n_dready = 0;
   int   lat;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .inst_req   (inst_req),
      .inst_addr  (inst_addr),
      .inst_rdata (inst_rdata),
      .inst_ready (inst_ready),
      .data_req   (data_req),
      .data_wen   (data_wen),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_rdata (data_rdata),
      .data_ready (data_ready),
      .bus        (bus.master),
      .stall_req  (stall_req)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (inst_ready === 1'b1) n_iready++;
      if (data_ready === 1'b1) n_dready++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] rfn(input logic [31:0] a);
      return (a == 32'h0000_0104) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_C3C3);
   endfunction

   task automatic chk32(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Serve the oldest scoreboard entry as the bus slave.
   task automatic run(input int aw, input int dw, output int l);
      exp_t        e;
      int          w;
      logic [31:0] rd;
      e = sb.pop_front();
      w = 0;
      while (bus.req !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      l = w;
      chk1("bus_req_seen", bus.req, 1'b1);
      chk32("bus_addr", bus.addr, e.addr);
      chk32("bus_wen", {28'b0, bus.wen}, {28'b0, e.wen});
      chk32("bus_wdata", bus.wdata, e.wdata);
      for (int i = 0; i < aw; i++) begin
         chk1("stall_addr", stall_req, 1'b1);
         tick();
         l++;
         chk1("req_hold", bus.req, 1'b1);
         chk32("addr_hold", bus.addr, e.addr);
      end
      bus.addr_ok = 1'b1;
      bus.data_ok = 1'b1;
      bus.rdata   = 32'hBAD0_0000;
      tick();
      l++;
      bus.addr_ok = 1'b0;
      bus.data_ok = 1'b0;
      chk1("req_drop", bus.req, 1'b0);
      for (int i = 0; i < dw; i++) begin
         chk1("stall_data", stall_req, 1'b1);
         chk1("early_ready", inst_ready | data_ready, 1'b0);
         tick();
         l++;
      end
      rd = rfn(e.addr);
      bus.data_ok = 1'b1;
      bus.rdata   = rd;
      tick();
      l++;
      bus.data_ok = 1'b0;
      bus.rdata   = 32'h1234_5678;
      chk1("data_ready", data_ready, e.is_data);
      chk1("inst_ready", inst_ready, ~e.is_data);
      chk32(e.is_data ? "data_rdata" : "inst_rdata",
            e.is_data ? data_rdata : inst_rdata, rd);
      tick();
      chk1("ready_single", inst_ready | data_ready, 1'b0);
   endtask

   task automatic push(input bit d, input logic [3:0] wen,
                       input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      e.is_data = d;
      e.wen     = wen;
      e.addr    = a;
      e.wdata   = wd;
      sb.push_back(e);
   endtask

   initial begin
      bus.addr_ok = 1'b0;
      bus.data_ok = 1'b0;
      bus.rdata   = '0;

      // reset state, stall follows its equation
      tick();
      data_req = 1'b1;
      #1;
      chk1("rst_stall_eq", stall_req, 1'b1);
      chk1("rst_bus_req", bus.req, 1'b0);
      data_req = 1'b0;
      #1;
      chk1("rst_stall_idle", stall_req, 1'b0);
      chk32("rst_rdata", data_rdata, 32'h0);
      chk1("rst_ready", inst_ready | data_ready, 1'b0);
      tick();
      rst = 1'b1;
      tick();

      // simultaneous requests after reset: data first
      inst_addr = 32'h0000_2000;
      data_addr = 32'h0000_0300;
      data_wen  = 4'b0000;
      inst_req  = 1'b1;
      data_req  = 1'b1;
      push(1'b1, 4'b0000, 32'h0000_0300, 32'h0);
      push(1'b0, 4'b0000, 32'h0000_2000, 32'h0);
      run(0, 0, lat);
      data_req = 1'b0;
      run(0, 0, lat);
      inst_req = 1'b0;
      tick();

      // single read with minimum latency
      data_addr = 32'h0000_0104;
      data_req  = 1'b1;
      push(1'b1, 4'b0000, 32'h0000_0104, 32'h0);
      run(0, 0, lat);
      chk32("read_latency", lat, 3);
      data_req = 1'b0;
      #1;
      chk1("stall_after", stall_req, 1'b0);
      tick();

      // byte write
      data_addr  = 32'h0000_0010;
      data_wen   = 4'b0100;
      data_wdata = 32'h00AB_0000;
      data_req   = 1'b1;
      push(1'b1, 4'b0100, 32'h0000_0010, 32'h00AB_0000);
      run(0, 0, lat);
      data_req = 1'b0;
      data_wen = 4'b0000;
      tick();

      // slave backpressure on a fetch
      inst_addr = 32'h0000_4440;
      inst_req  = 1'b1;
      push(1'b0, 4'b0000, 32'h0000_4440, 32'h0);
      run(5, 3, lat);
      chk32("bp_latency", lat, 1 + 5 + 1 + 3 + 1);
      inst_req = 1'b0;
      tick();

      // repeated ties alternate data, inst, data, inst
      inst_addr  = 32'h0000_8000;
      data_addr  = 32'h0000_0200;
      data_wen   = 4'b0011;
      data_wdata = 32'h0000_CAFE;
      inst_req   = 1'b1;
      data_req   = 1'b1;
      for (int k = 0; k < 2; k++) begin
         push(1'b1, 4'b0011, 32'h0000_0200, 32'h0000_CAFE);
         push(1'b0, 4'b0000, 32'h0000_8000, 32'h0);
      end
      for (int k = 0; k < 4; k++) run(k % 3, k % 2, lat);
      inst_req = 1'b0;
      data_req = 1'b0;
      data_wen = 4'b0000;
      tick();

      // asynchronous reset in the data phase
      inst_addr = 32'h0000_0C00;
      inst_req  = 1'b1;
      tick();
      chk1("ar_addr_phase", bus.req, 1'b1);
      bus.addr_ok = 1'b1;
      tick();
      bus.addr_ok = 1'b0;
      #2;
      rst      = 1'b0;
      inst_req = 1'b0;
      #1;
      chk1("ar_bus_req", bus.req, 1'b0);
      chk32("ar_bus_addr", bus.addr, 32'h0);
      chk32("ar_rdata", inst_rdata, 32'h0);
      chk1("ar_ready", inst_ready | data_ready, 1'b0);
      chk1("ar_stall", stall_req, 1'b0);
      bus.data_ok = 1'b1;
      bus.rdata   = 32'hFFFF_FFFF;
      tick();
      bus.data_ok = 1'b0;
      #2;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("ar_no_pulse", inst_ready | data_ready, 1'b0);
      end
      inst_addr = 32'h0000_0D00;
      inst_req  = 1'b1;
      push(1'b0, 4'b0000, 32'h0000_0D00, 32'h0);
      run(1, 1, lat);
      inst_req = 1'b0;
      tick();
      tick();

      chk32("inst_pulses", n_iready, 5);
      chk32("data_pulses", n_dready, 5);
      chk32("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
